// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and helpers for the up/down counter
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Packs an integer into up to 8 BCD digits; used only at elaboration.
  function automatic logic [31:0] to_bcd(input int value, input int ndig);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < ndig) begin
        r[i*BCD_W +: BCD_W] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic is_term(input logic [3:0] digit, input logic ud);
    return ud ? (digit == BCD_MIN) : (digit == BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit with load clamping and 9/0 wrap
import bcd_pkg::*;

module bcd_digit_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_in,
  input  logic       ud,
  input  logic       load,
  input  logic [3:0] ld_digit,
  input  logic [3:0] rst_digit,
  output logic [3:0] digit,
  output logic       ce_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= rst_digit;
    end else if (load) begin
      digit <= (ld_digit > BCD_MAX) ? BCD_MAX : ld_digit;
    end else if (ce_in) begin
      if (ud)
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      else
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
    end
  end

  // Carry/borrow ripples combinationally so every digit moves on the same edge.
  assign ce_out = ce_in & is_term(digit, ud);

endmodule

// File: rtl/bcd_updown_counter_ndig.sv
// rtl/bcd_updown_counter_ndig.sv - N-digit BCD up/down counter with load, wrap/saturate and flags
import bcd_pkg::*;

module bcd_updown_counter_ndig #(
  parameter int NDIG     = 4,
  parameter int RST_VAL  = 0,
  parameter int WRAP_DEF = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ud,
  input  logic                  load,
  input  logic [4*NDIG-1:0]     load_val,
  input  logic                  sat_mode,
  output logic [4*NDIG-1:0]     cnt,
  output logic                  tc,
  output logic                  wrap_p,
  output logic                  sat,
  output logic                  load_err
);

  generate
    if (NDIG < 1 || NDIG > 8 || WRAP_DEF < 0 || WRAP_DEF > 1) begin : g_param_check
      $error("bcd_updown_counter_ndig: NDIG must be 1..8 and WRAP_DEF 0 or 1");
    end
  endgenerate

  localparam logic [31:0] RST_BCD = to_bcd(RST_VAL, NDIG);

  logic [NDIG:0] ce;
  logic          all_term;
  logic          load_bad;

  always_comb begin
    all_term = 1'b1;
    load_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      all_term = all_term & is_term(cnt[i*BCD_W +: BCD_W], ud);
      load_bad = load_bad | (load_val[i*BCD_W +: BCD_W] > BCD_MAX);
    end
  end

  // In saturate mode the chain is never started at terminal count, so cnt holds.
  assign ce[0] = en & ~load & ~(sat_mode & all_term);

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_in     (ce[g]),
        .ud        (ud),
        .load      (load),
        .ld_digit  (load_val[g*BCD_W +: BCD_W]),
        .rst_digit (RST_BCD[g*BCD_W +: BCD_W]),
        .digit     (cnt[g*BCD_W +: BCD_W]),
        .ce_out    (ce[g+1])
      );
    end
  endgenerate

  // ce[NDIG] covers the wrapping case; the second term covers the held case.
  assign tc = ce[NDIG] | (en & ~load & sat_mode & all_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_p   <= 1'b0;
      sat      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap_p <= 1'b0;
      sat    <= 1'b0;
      if (load_bad)
        load_err <= 1'b1;
    end else if (en) begin
      wrap_p <= tc & ~sat_mode;
      sat    <= tc & sat_mode;
    end else begin
      wrap_p <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_ndig.sv
// tb/tb_bcd_updown_counter_ndig.sv - directed scoreboard bench for the 4-digit BCD counter
module tb_bcd_updown_counter_ndig;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        wrap_p;
    logic        sat;
    logic        load_err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        ud;
  logic        load;
  logic [15:0] load_val;
  logic        sat_mode;
  logic [15:0] cnt;
  logic        tc;
  logic        wrap_p;
  logic        sat;
  logic        load_err;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bcd_updown_counter_ndig #(.NDIG(4), .RST_VAL(0), .WRAP_DEF(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ud       (ud),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .cnt      (cnt),
    .tc       (tc),
    .wrap_p   (wrap_p),
    .sat      (sat),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd16(input int value);
    logic [15:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push(input string tag, input logic [15:0] c, input logic w,
                      input logic s, input logic e);
    exp_t x;
    x.tag = tag; x.cnt = c; x.wrap_p = w; x.sat = s; x.load_err = e;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    x = sb.pop_front();
    total++;
    assert (cnt === x.cnt) else begin
      bad++; $error("FAIL %s.cnt got=%h exp=%h", x.tag, cnt, x.cnt);
    end
    total++;
    assert (wrap_p === x.wrap_p) else begin
      bad++; $error("FAIL %s.wrap_p got=%b exp=%b", x.tag, wrap_p, x.wrap_p);
    end
    total++;
    assert (sat === x.sat) else begin
      bad++; $error("FAIL %s.sat got=%b exp=%b", x.tag, sat, x.sat);
    end
    total++;
    assert (load_err === x.load_err) else begin
      bad++; $error("FAIL %s.load_err got=%b exp=%b", x.tag, load_err, x.load_err);
    end
  endtask

  task automatic check_tc(input string tag, input logic exp_tc);
    total++;
    assert (tc === exp_tc) else begin
      bad++; $error("FAIL %s.tc got=%b exp=%b", tag, tc, exp_tc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; en = 1'b0; load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ud = 1'b0; load = 1'b0; load_val = '0; sat_mode = 1'b0;
    #2;
    push("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    pop_check();
    check_tc("reset", 1'b0);
    rst_n = 1'b1;

    // Count up ten edges from 0; 0009 -> 0010 carries on one edge.
    en = 1'b1; ud = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push($sformatf("up%0d", i), bcd16(i), 1'b0, 1'b0, 1'b0);
      tick();
      pop_check();
    end
    en = 1'b0;

    do_load(16'h0999);
    push("ld0999", 16'h0999, 1'b0, 1'b0, 1'b0);
    pop_check();
    en = 1'b1; ud = 1'b0;
    #1 check_tc("pre1000", 1'b0);
    push("to1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check();
    check_tc("at1000", 1'b0);
    en = 1'b0;

    sat_mode = 1'b0;
    do_load(16'h9999);
    check_tc("9999_idle", 1'b0);
    en = 1'b1; ud = 1'b0;
    #1 check_tc("9999_up", 1'b1);
    push("wrap_up", 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    pop_check();
    en = 1'b0;
    push("wrap_up_end", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check();

    en = 1'b1; ud = 1'b1;
    #1 check_tc("0000_down", 1'b1);
    push("wrap_dn", 16'h9999, 1'b1, 1'b0, 1'b0);
    tick();
    pop_check();
    en = 1'b0;
    push("wrap_dn_end", 16'h9999, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check();

    sat_mode = 1'b1;
    do_load(16'h0000);
    en = 1'b1; ud = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_tc($sformatf("sat_tc%0d", i), 1'b1);
      push($sformatf("sat%0d", i), 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      pop_check();
    end
    ud = 1'b0;
    push("sat_rev", 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check();
    en = 1'b0; sat_mode = 1'b0;

    do_load(16'h12F4);
    push("ld_bad", 16'h1294, 1'b0, 1'b0, 1'b1);
    pop_check();
    do_load(16'h0455);
    push("ld_sticky", 16'h0455, 1'b0, 1'b0, 1'b1);
    pop_check();
    en = 1'b1; ud = 1'b0;
    push("up456", 16'h0456, 1'b0, 1'b0, 1'b1);
    tick();
    pop_check();
    push("up457", 16'h0457, 1'b0, 1'b0, 1'b1);
    tick();
    pop_check();

    // Asynchronous reset between edges while still counting.
    #2 rst_n = 1'b0;
    #1;
    push("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    pop_check();
    #1 rst_n = 1'b1;
    tick();

    load = 1'b1; en = 1'b1; load_val = 16'h0321;
    push("ld_wins", 16'h0321, 1'b0, 1'b0, 1'b0);
    tick();
    pop_check();
    load = 1'b0; en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_updown_counter_ndig.md
Name: bcd_updown_counter_ndig

Overview:
Parametrised N-digit BCD up/down counter. It is the multi-digit successor of the single-digit cascade counter: the digit chain, load, saturate/wrap mode and terminal-count flags live inside one block. It sits between the debounced switch/button logic and the 7-segment display multiplexer. It drives packed BCD digits directly to the display path.

Parameters:
NDIG, 4, number of BCD digits (1..8)
RST_VAL, 0, reset count as an integer (0..10^NDIG-1), converted to BCD at elaboration
WRAP_DEF, 1, unused by logic; documents the intended board default for sat_mode=0

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable, sampled each rising clk edge
ud  input  1  direction: 0 = count up, 1 = count down
load  input  1  synchronous parallel load, priority over en
load_val  input  4*NDIG  packed BCD load value, digit 0 in bits [3:0]
sat_mode  input  1  0 = wrap at terminal count, 1 = saturate (hold)
cnt  output  4*NDIG  packed BCD count, digit 0 = least significant
tc  output  1  combinational: en & ~load & all digits at terminal (9 for up, 0 for down)
wrap_p  output  1  registered one-cycle pulse: the count wrapped on the previous edge
sat  output  1  registered: the count is held at terminal in saturate mode
load_err  output  1  sticky: a load contained a digit > 9; cleared only by reset

Behaviour:
- Reset (rst_n=0, asynchronous): cnt = BCD(RST_VAL), wrap_p=0, sat=0, load_err=0. Release is synchronous to clk at the first edge.
- Priority on each edge: load > en > hold.
- Load:
  - cnt <= load_val, digit by digit.
  - Any digit > 9 is clamped to 9 and sets load_err.
  - wrap_p <= 0; sat <= 0.
- Count (en=1, load=0), digit i increments or decrements when ce[i]=1:
  - ce[0] = en.
  - ce[i+1] = ce[i] & (ud ? d[i]==0 : d[i]==9).
  - Up: 9 -> 0. Down: 0 -> 9.
- Ripple is combinational, so all digits update on the same edge. Zero latency from en to cnt change (one edge).
- Terminal case (tc=1):
  - sat_mode=0: all digits wrap (up: 99..9 -> 00..0; down: 00..0 -> 99..9); wrap_p <= 1 for exactly one cycle.
  - sat_mode=1: cnt holds, sat <= 1, wrap_p <= 0.
- sat clears on the first edge where the count changes (reversed direction, load, or sat_mode=0 with wrap).
- Idle (en=0, load=0): cnt holds; wrap_p <= 0; sat holds.
- Direction change mid-count takes effect on the next edge. There is no pipeline state to flush.
- A mid-operation reset aborts immediately; no partial digit update is visible after reset.
- tc is a pure function of the current cnt, en, ud and load. Used for cascading multiple instances: feed tc into the next instance's en.
- cnt digits are always valid BCD (0..9) at every clock edge.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W = 4; BCD_MAX = 4'd9; BCD_MIN = 4'd0.
  - Function to_bcd(int, ndig) for RST_VAL conversion.
  - Function is_term(digit, ud).
- Sub-module bcd_digit_cell, one per digit via a generate loop:
  - Ports: clk, rst_n, ce_in, ud, load, ld_digit, rst_digit.
  - Outputs: digit, ce_out.
  - It owns clamping and per-digit wrap.
- The top level owns tc, wrap_p, sat and load_err.

Test Plan:
- NDIG=4, reset with RST_VAL=0; ud=0, en=1 for 10 edges -> cnt=0x0010. Edge 9->10 carries with no stall cycle.
- Load 0x0999, ud=0, en=1, one edge -> cnt=0x1000; tc=0 throughout; wrap_p=0.
- Load 0x9999, sat_mode=0, ud=0 -> tc=1 before the edge; after the edge cnt=0x0000 and wrap_p=1 for exactly one cycle. Down from 0x0000 -> 0x9999 with wrap_p=1.
- Load 0x0000, sat_mode=1, ud=1, en=1 for 3 edges -> cnt stays 0x0000 and sat=1. Set ud=0 -> next edge cnt=0x0001, sat=0.
- Load 0x12F4 -> cnt=0x1294 and load_err=1. load_err stays set after further loads until rst_n=0.
- Pulse rst_n low asynchronously mid-count at cnt=0x0457 (between edges) -> cnt=BCD(RST_VAL) immediately and all flags 0. Load and en asserted together -> the load value wins.
